// File: rtl/alu_sequencer.sv
// Operation sequencer for an external 32-bit AND/OR/ADD ALU: single-cycle AND/OR/ADD/SUB/SLT
// and a 32-cycle shift-add multiply, with valid/ready request and response handshakes.
module alu_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_carry,
   output logic        rsp_overflow,
   output logic        rsp_illegal,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic        alu_binvert,
   output logic        alu_carryin,
   output logic [1:0]  alu_operation,
   input  logic [31:0] alu_result,
   input  logic        alu_carryout
);

   typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;

   state_t      state, state_nxt;
   logic [2:0]  op_q;
   logic [31:0] a_q;     // operand A; doubles as the multiplicand during MUL
   logic [31:0] b_q;     // operand B; doubles as the multiplier during MUL
   logic [31:0] acc;
   logic [4:0]  cnt;
   logic [31:0] b_eff;
   logic        ovf;
   logic        slt_bit;
   logic [31:0] mul_next;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_valid) state_nxt = (req_op == OP_MUL) ? MUL : EXEC;
         EXEC: state_nxt = RESP;
         MUL:  if (cnt == 5'd31) state_nxt = RESP;
         RESP: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready     = (state == IDLE);
      rsp_valid     = (state == RESP);
      alu_a         = '0;
      alu_b         = '0;
      alu_binvert   = 1'b0;
      alu_carryin   = 1'b0;
      alu_operation = 2'b00;
      if (state == EXEC) begin
         case (op_q)
            OP_AND: begin alu_a = a_q; alu_b = b_q; alu_operation = 2'b00; end
            OP_OR:  begin alu_a = a_q; alu_b = b_q; alu_operation = 2'b01; end
            OP_ADD: begin alu_a = a_q; alu_b = b_q; alu_operation = 2'b10; end
            OP_SUB, OP_SLT: begin
               alu_a         = a_q;
               alu_b         = b_q;
               alu_operation = 2'b10;
               alu_binvert   = 1'b1;
               alu_carryin   = 1'b1;
            end
            default: ;
         endcase
      end else if (state == MUL) begin
         alu_a         = acc;
         alu_b         = a_q;
         alu_operation = 2'b10;
      end
   end

   // Flags derived from the operand the ALU actually added (B or ~B).
   assign b_eff    = alu_binvert ? ~b_q : b_q;
   assign ovf      = (a_q[31] == b_eff[31]) && (alu_result[31] != a_q[31]);
   assign slt_bit  = alu_result[31] ^ ovf;
   assign mul_next = b_q[0] ? alu_result : acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         acc          <= '0;
         cnt          <= '0;
         rsp_result   <= '0;
         rsp_zero     <= 1'b0;
         rsp_carry    <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_illegal  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               op_q <= req_op;
               a_q  <= req_a;
               b_q  <= req_b;
               acc  <= '0;
               cnt  <= '0;
            end
            EXEC: begin
               rsp_illegal <= 1'b0;
               case (op_q)
                  OP_AND, OP_OR: begin
                     rsp_result   <= alu_result;
                     rsp_zero     <= (alu_result == '0);
                     rsp_carry    <= 1'b0;
                     rsp_overflow <= 1'b0;
                  end
                  OP_ADD, OP_SUB: begin
                     rsp_result   <= alu_result;
                     rsp_zero     <= (alu_result == '0);
                     rsp_carry    <= alu_carryout;
                     rsp_overflow <= ovf;
                  end
                  OP_SLT: begin
                     rsp_result   <= {31'b0, slt_bit};
                     rsp_zero     <= ~slt_bit;
                     rsp_carry    <= alu_carryout;
                     rsp_overflow <= ovf;
                  end
                  default: begin
                     rsp_result   <= '0;
                     rsp_zero     <= 1'b1;
                     rsp_carry    <= 1'b0;
                     rsp_overflow <= 1'b0;
                     rsp_illegal  <= 1'b1;
                  end
               endcase
            end
            MUL: begin
               acc <= mul_next;
               a_q <= a_q << 1;
               b_q <= b_q >> 1;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  rsp_result   <= mul_next;
                  rsp_zero     <= (mul_next == '0);
                  rsp_carry    <= 1'b0;
                  rsp_overflow <= 1'b0;
                  rsp_illegal  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU, arithmetic reference model,
// directed corner cases plus randomized operations with random response backpressure.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_zero;
   logic        rsp_carry;
   logic        rsp_overflow;
   logic        rsp_illegal;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic        alu_binvert;
   logic        alu_carryin;
   logic [1:0]  alu_operation;
   logic [31:0] alu_result;
   logic        alu_carryout;

   int n_checks = 0;
   int n_fail   = 0;

   alu_sequencer dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
      .rsp_illegal(rsp_illegal),
      .alu_a(alu_a), .alu_b(alu_b), .alu_binvert(alu_binvert),
      .alu_carryin(alu_carryin), .alu_operation(alu_operation),
      .alu_result(alu_result), .alu_carryout(alu_carryout)
   );

   always #5 clk = ~clk;

   // External combinational ALU
   logic [31:0] alu_bp;
   logic [32:0] alu_sum;
   always_comb begin
      alu_bp       = alu_binvert ? ~alu_b : alu_b;
      alu_sum      = {1'b0, alu_a} + {1'b0, alu_bp} + {32'b0, alu_carryin};
      alu_carryout = alu_sum[32];
      case (alu_operation)
         2'b00:   alu_result = alu_a & alu_bp;
         2'b01:   alu_result = alu_a | alu_bp;
         2'b10:   alu_result = alu_sum[31:0];
         default: alu_result = 32'h0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model straight from the arithmetic definition of each operation
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z, output logic c,
                        output logic v, output logic ill);
      logic [32:0] wide;
      logic [31:0] diff;
      r = 32'h0; c = 1'b0; v = 1'b0; ill = 1'b0;
      diff = a - b;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: begin
            wide = {1'b0, a} + {1'b0, b};
            r = wide[31:0];
            c = wide[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         3'd3: begin
            r = diff;
            c = (a >= b);
            v = (a[31] != b[31]) && (diff[31] != a[31]);
         end
         3'd4: begin
            r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            c = (a >= b);
            v = (a[31] != b[31]) && (diff[31] != a[31]);
         end
         3'd5: r = a * b;
         default: ill = 1'b1;
      endcase
      z = (r == 32'h0);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
      logic [31:0] e_r;
      logic e_z, e_c, e_v, e_ill;
      int lat;
      int budget;
      model(op, a, b, e_r, e_z, e_c, e_v, e_ill);
      budget = 0;
      while (!req_ready && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      check("req_ready_idle", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      @(negedge clk);
      req_valid = 1'b0; req_op = 3'($urandom); req_a = $urandom; req_b = $urandom;
      lat = 1;
      while (!rsp_valid && lat < 100) begin
         if (lat == 1 && op <= 3'd4) begin
            check("exec_alu_a", alu_a, a);
            check("exec_alu_b", alu_b, b);
            check("exec_alu_op", {30'b0, alu_operation}, (op == 3'd0) ? 32'd0 : (op == 3'd1) ? 32'd1 : 32'd2);
            check("exec_binv_cin", {30'b0, alu_binvert, alu_carryin},
                  (op == 3'd3 || op == 3'd4) ? 32'd3 : 32'd0);
         end else if (lat == 1 && op == 3'd5) begin
            check("mul_alu_a", alu_a, 32'h0);
            check("mul_alu_b", alu_b, a);
            check("mul_alu_op", {29'b0, alu_operation, alu_binvert}, 32'd4);
         end
         @(negedge clk);
         lat++;
      end
      check("latency", lat, (op == 3'd5) ? 32'd33 : 32'd2);
      for (int i = 0; i <= hold; i++) begin
         if (i > 0) @(negedge clk);
         check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
         check("req_ready_busy", {31'b0, req_ready}, 32'd0);
         check("result", rsp_result, e_r);
         check("flags", {28'b0, rsp_zero, rsp_carry, rsp_overflow, rsp_illegal},
               {28'b0, e_z, e_c, e_v, e_ill});
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("req_ready_after", {31'b0, req_ready}, 32'd1);
      check("rsp_valid_after", {31'b0, rsp_valid}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp", {rsp_result[27:0], rsp_zero, rsp_carry, rsp_overflow, rsp_illegal}, 32'd0);
      check("rst_alu", alu_a | alu_b | {29'b0, alu_binvert, alu_operation} | {31'b0, alu_carryin}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op(3'd0, 32'ha5a5a5a5, 32'h5a5a5a5a, 0);
      run_op(3'd1, 32'ha5a5a5a5, 32'h5a5a5a5a, 0);
      run_op(3'd2, 32'hffffffff, 32'h00000001, 0);
      run_op(3'd3, 32'h7fffffff, 32'hffffffff, 0);
      run_op(3'd4, 32'hffffffff, 32'h00000001, 0);
      run_op(3'd4, 32'h7fffffff, 32'h80000000, 0);
      run_op(3'd5, 32'h00012345, 32'h00000100, 0);
      run_op(3'd5, 32'hffffffff, 32'hffffffff, 0);
      run_op(3'd3, 32'h12345678, 32'h12345678, 5);
      run_op(3'd6, 32'hdeadbeef, 32'h00000001, 0);
      run_op(3'd7, 32'h00000000, 32'h00000000, 2);

      // Reset during the 10th MUL cycle discards the operation
      req_valid = 1'b1; req_op = 3'd5; req_a = 32'h00000003; req_b = 32'h00000007;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midmul_req_ready", {31'b0, req_ready}, 32'd1);
      check("midmul_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("midmul_rsp_result", rsp_result, 32'h0);
      repeat (40) @(negedge clk);
      check("midmul_discarded", {31'b0, rsp_valid}, 32'd0);

      for (int i = 0; i < 25; i++) begin
         logic [2:0] rop;
         rop = 3'($urandom_range(0, 7));
         run_op(rop, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom,
                $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
